// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// 2-entry prefetch FIFO feeding IF/ID, branch redirect with squash of an in-flight read.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        R,
  input  logic        LE,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] rom_instruction,
  output logic [31:0] pc_plus_4,
  output logic        fetch_valid
);

  typedef enum logic {S_FETCH, S_SQUASH} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [1:0]  count_q, count_d;
  logic        run_q;
  logic [63:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [31:0] pc_inc;
  logic [63:0] new_ent;
  logic        xfer, push, pop;

  always_comb begin
    pc_inc          = fetch_pc_q + 32'd4;
    new_ent         = {imem_data, pc_inc};
    fetch_valid     = (count_q != 2'd0);
    rom_instruction = fetch_valid ? ent0_q[63:32] : 32'h0;
    pc_plus_4       = fetch_valid ? ent0_q[31:0]  : 32'h0;
    // run_q keeps the request low for one cycle after any reset edge.
    imem_req        = run_q && !R && ((state_q == S_SQUASH) || (count_q != 2'd2));
    imem_addr       = (state_q == S_SQUASH) ? hold_addr_q : fetch_pc_q;
    xfer            = imem_req && imem_ack;
    push            = xfer && (state_q == S_FETCH) && !branch_taken;
    pop             = LE && fetch_valid && !branch_taken;
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    count_d     = count_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    if (branch_taken) begin
      count_d    = 2'd0;
      fetch_pc_d = {branch_target[31:2], 2'b00};
      // An unanswered read must still complete at its old address; its data is dropped.
      if ((state_q == S_FETCH) && imem_req && !imem_ack) begin
        state_d     = S_SQUASH;
        hold_addr_d = fetch_pc_q;
      end else if ((state_q == S_SQUASH) && xfer) begin
        state_d = S_FETCH;
      end
    end else begin
      if (state_q == S_SQUASH) begin
        if (xfer) state_d = S_FETCH;
      end else if (push) begin
        fetch_pc_d = pc_inc;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = new_ent;
          else                 ent1_d = new_ent;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = new_ent;
          end else begin
            ent0_d = ent1_q;
            ent1_d = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      count_q    <= 2'd0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      run_q      <= 1'b1;
    end
  end

  // FIFO payload and held address carry no reset; count and state qualify them.
  always_ff @(posedge clk) begin
    ent0_q      <= ent0_d;
    ent1_q      <= ent1_d;
    hold_addr_q <= hold_addr_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected instructions are queued as fetches are
// issued and a monitor compares them whenever IF/ID accepts a presented instruction.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        R;
  logic        LE;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] rom_instruction;
  logic [31:0] pc_plus_4;
  logic        fetch_valid;

  int applied = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut (
    .clk(clk), .R(R), .LE(LE), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rom_instruction(rom_instruction), .pc_plus_4(pc_plus_4), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  // Memory image: the word at address a is a + 0x1000_0000.
  assign imem_data = imem_addr + 32'h1000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic cyc(input logic r, input logic le, input logic br,
                     input logic [31:0] tgt, input logic ack);
    @(posedge clk);
    #1;
    R = r; LE = le; branch_taken = br; branch_target = tgt; imem_ack = ack;
    @(negedge clk);
  endtask

  task automatic expect_item(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  // Scoreboard monitor: every instruction taken by IF/ID must be the next expected one.
  always @(negedge clk) begin
    if (!R && LE && fetch_valid && !branch_taken) begin
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL presented: got %h/%h, required no instruction", rom_instruction, pc_plus_4);
      end else begin
        chk("presented", {rom_instruction, pc_plus_4}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] a_addr  [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
  logic [31:0] a_instr [5] = '{32'h0FFF_FFF8, 32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
  logic [31:0] a_pc4   [5] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};

  initial begin
    R = 1'b1; LE = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; imem_ack = 1'b0;

    // Reset, then zero-wait streaming across the 32-bit wrap
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, fetch_valid}, 64'h0);
    chk("rst_instr", {32'h0, rom_instruction}, 64'h0);
    chk("rst_pc4", {32'h0, pc_plus_4}, 64'h0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("post_rst_req", {63'h0, imem_req}, 64'h0);
    chk("post_rst_valid", {63'h0, fetch_valid}, 64'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 32'h0, 1);
      chk("stream_req", {63'h0, imem_req}, 64'h1);
      chk("stream_addr", {32'h0, imem_addr}, {32'h0, a_addr[i]});
      chk("stream_valid", {63'h0, fetch_valid}, {63'h0, (i != 0)});
      expect_item(a_instr[i], a_pc4[i]);
    end

    // Stall with LE=0: exactly two transfers, head steady
    cyc(0, 1, 0, 32'h0, 0);
    chk("drain_addr", {32'h0, imem_addr}, 64'h0000_000C);
    cyc(0, 0, 0, 32'h0, 1);
    chk("stall1_addr", {32'h0, imem_addr}, 64'h0000_000C);
    expect_item(32'h1000_000C, 32'h0000_0010);
    cyc(0, 0, 0, 32'h0, 1);
    chk("stall2_addr", {32'h0, imem_addr}, 64'h0000_0010);
    chk("stall2_head", {32'h0, rom_instruction}, 64'h1000_000C);
    expect_item(32'h1000_0010, 32'h0000_0014);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 32'h0, 1);
      chk("stall_full_req", {63'h0, imem_req}, 64'h0);
      chk("stall_head", {rom_instruction, pc_plus_4}, {32'h1000_000C, 32'h0000_0010});
    end
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0);
    chk("release_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0000_0014});

    // Branch with a full FIFO to an unaligned target
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 1, 1, 32'h0000_0103, 1);
    chk("br_full_valid", {63'h0, fetch_valid}, 64'h1);
    chk("br_full_req", {63'h0, imem_req}, 64'h0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("br_flush_valid", {63'h0, fetch_valid}, 64'h0);
    chk("br_target_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0000_0100});
    expect_item(32'h1000_0100, 32'h0000_0104);
    cyc(0, 1, 0, 32'h0, 0);
    chk("br_next_addr", {32'h0, imem_addr}, 64'h0000_0104);

    // Branch on a stalled read, then a second branch while squashing
    cyc(0, 1, 1, 32'h0000_0300, 0);
    cyc(0, 1, 1, 32'h0000_0200, 0);
    chk("sq_hold1", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0000_0104});
    cyc(0, 1, 0, 32'h0, 0);
    chk("sq_hold2", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0000_0104});
    cyc(0, 1, 0, 32'h0, 1);
    chk("sq_ack_addr", {32'h0, imem_addr}, 64'h0000_0104);
    cyc(0, 1, 0, 32'h0, 1);
    chk("sq_discard_valid", {63'h0, fetch_valid}, 64'h0);
    chk("sq_new_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0000_0200});
    expect_item(32'h1000_0200, 32'h0000_0204);
    cyc(0, 1, 0, 32'h0, 0);

    // Reset pulsed during squash
    cyc(0, 1, 1, 32'h0000_0400, 0);
    cyc(0, 1, 0, 32'h0, 0);
    chk("sq2_hold", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0000_0204});
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("sq_rst_req", {63'h0, imem_req}, 64'h0);
    chk("sq_rst_valid", {63'h0, fetch_valid}, 64'h0);
    chk("sq_rst_out", {rom_instruction, pc_plus_4}, 64'h0);
    cyc(0, 1, 0, 32'h0, 1);
    chk("restart_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hFFFF_FFF8});
    expect_item(32'h0FFF_FFF8, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 32'h0, 0);
    chk("restart_next", {32'h0, imem_addr}, 64'hFFFF_FFFC);

    // Data acked in the branch cycle is dropped
    cyc(0, 1, 1, 32'h0000_0500, 1);
    cyc(0, 1, 0, 32'h0, 1);
    chk("br_ack_valid", {63'h0, fetch_valid}, 64'h0);
    chk("br_ack_addr", {32'h0, imem_addr}, 64'h0000_0500);
    expect_item(32'h1000_0500, 32'h0000_0504);
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0);
    chk("pending_expected", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
